mips_sramlike_bridge: RTL
=========================

# mips_sramlike_bridge

Converts the core's single-cycle SRAM-style instruction and data ports into handshaked SRAM-like bus channels (req/addr_ok/data_ok). It sits between the `mips` core and the memory or cache side. Each channel runs its own request state machine and holds returned data until both channels complete. A shared stall output freezes the core pipeline while any enabled access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32, address width of both channels
- `DATA_W`, 32, data width; must be 32 (byte-enable/size encoding assumes 4 lanes)
- `MAX_POSTED`, 3, maximum outstanding posted writes (only with `SRAMLIKE_POSTED_WR_EN`)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `inst_sram_en`  in  1  core instruction fetch request
- `inst_sram_addr`  in  ADDR_W  fetch address
- `inst_sram_rdata`  out  DATA_W  fetched word (valid when `stall`=0)
- `data_sram_en`  in  1  core data access request
- `data_sram_wen`  in  4  byte write enables; 0 = read
- `data_sram_addr`  in  ADDR_W  data address
- `data_sram_wdata`  in  DATA_W  store data
- `data_sram_rdata`  out  DATA_W  load data (valid when `stall`=0)
- `stall`  out  1  core pipeline freeze
- `inst_req`, `data_req`  out  1  bus request
- `inst_wr`, `data_wr`  out  1  write (`inst_wr` tied 0)
- `inst_size`, `data_size`  out  2  0 = byte, 1 = half, 2 = word
- `inst_addr`, `data_addr`  out  ADDR_W  bus address
- `inst_wdata`, `data_wdata`  out  DATA_W  bus write data
- `inst_rdata`, `data_rdata`  in  DATA_W  bus read data
- `inst_addr_ok`, `data_addr_ok`  in  1  address accepted
- `inst_data_ok`, `data_data_ok`  in  1  response / read data valid

## Operation
- Per-channel FSM with states IDLE, ADDR, DATA, DONE.
- IDLE with en=1: assert `req` combinationally.
  - `addr_ok`=1 in the same cycle: go to DATA.
  - `addr_ok`=0: go to ADDR.
- ADDR: `req` held high with addr/size/wr/wdata stable. On `addr_ok`, go to DATA.
- DATA: on `data_ok`, capture `*_rdata` into the channel buffer and go to DONE.
- DONE: buffer drives `*_sram_rdata`. Leave DONE for IDLE in the cycle `stall`=0.
- `data_ok` is sampled only in DATA (except for posted-write drain; see Configuration). `data_ok` seen in IDLE/ADDR/DONE is ignored.
- A channel with en=0 counts as complete.
- `stall` = (inst channel enabled and not in DONE) OR (data channel enabled and not in DONE).
  - `stall` is combinational from state and en.
  - When `stall`=0, both channels in DONE return to IDLE together. The core advances that cycle.
- Size encoding:
  - `wen`=0: read, size 2, address passed through.
  - `1111`: size 2.
  - `0011` / `1100`: size 1.
  - One-hot: size 0.
  - Any other pattern: size 2.
  - `wdata` is passed unmodified.
- Instruction channel is always a word read.

## Timing
- Reset: all FSMs IDLE, buffers 0, posted counter 0.
- Reset values of outputs: `*_sram_rdata`=0. `req`=0 and `stall`=0 while en=0.
- Minimum access: `addr_ok` in cycle 0, `data_ok` in cycle 1.
  - `stall` high in cycles 0–1.
  - Cycle 2: DONE, `stall`=0, rdata valid.
  - Two-cycle stall minimum.
- Both channels complete independently. `stall` falls only after the later one reaches DONE.
- Earlier-finishing channel holds its buffer, with `req`=0, until release.
- Reset mid-transaction: return to IDLE next edge. A late `data_ok` for the aborted access is ignored.

## Configuration
- Macro `SRAMLIKE_POSTED_WR_EN`, data channel only.
- Without the macro: writes wait for `data_ok` like reads (ADDR → DATA → DONE).
- With the macro:
  - A write moves to DONE on `addr_ok` and increments the posted counter.
  - While the counter equals `MAX_POSTED`, no new `data_req` is asserted; the channel stays in IDLE/ADDR, so `stall` stays high.
  - Any `data_data_ok` arriving while the counter > 0 decrements it and is not captured.
  - A read in DATA captures only the first `data_ok` after the counter reaches 0.
  - Counter increment and decrement in the same cycle leave it unchanged.

## Test plan
- Fetch only, `addr_ok` immediately, `data_ok` next cycle with 0x24020005:
  - `stall` high 2 cycles.
  - `inst_sram_rdata`=0x24020005 on release.
- Fetch done in 2 cycles, load with `addr_ok` delayed 3 cycles and rdata 0xDEADBEEF:
  - `stall` stays high until the load reaches DONE.
  - Both rdata values valid on the same release cycle.
- Stores with `wen`=1111/1100/0100:
  - `data_size`=2/1/0, `data_wr`=1.
  - `data_addr` and `data_wdata` stable while `addr_ok`=0.
- `rst` asserted in DATA state:
  - Next cycle IDLE, `stall`=0 with en=0.
  - Subsequent stray `data_ok` leaves rdata=0.
- With macro: 3 back-to-back stores, each accepted at `addr_ok`, no `data_ok` returned.
  - Each store's stall lasts 1 cycle.
  - 4th store stalls until one `data_ok` arrives.
- With macro: 2 posted writes pending, then a load; three `data_ok` pulses, the last with 0x12345678.
  - Load captures 0x12345678 only.
  - Counter ends at 0.

Source files
------------

// File: rtl/mips_sramlike_bridge.sv
// Bridges the core's single-cycle SRAM ports onto req/addr_ok/data_ok SRAM-like channels.
// Optional feature: define SRAMLIKE_POSTED_WR_EN to retire data-channel writes at address acceptance.
module mips_sramlike_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_POSTED = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_sram_en,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    output logic [DATA_W-1:0] inst_sram_rdata,

    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic [DATA_W-1:0] data_sram_rdata,

    output logic              stall,

    output logic              inst_req,
    output logic              inst_wr,
    output logic [1:0]        inst_size,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_wdata,
    input  logic [DATA_W-1:0] inst_rdata,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,

    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    if (DATA_W != 32 || MAX_POSTED < 1) begin : g_cfg_check
        $error("mips_sramlike_bridge: DATA_W must be 32 and MAX_POSTED at least 1");
    end

    // Byte-enable pattern to bus transfer size; irregular masks fall back to a word.
    function automatic logic [1:0] size_of(input logic [3:0] wen);
        logic [1:0] size;
        case (wen)
            4'b0011, 4'b1100:                   size = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
            default:                            size = 2'd2;
        endcase
        return size;
    endfunction

    state_t            inst_state;
    state_t            data_state;
    logic [ADDR_W-1:0] inst_addr_q;
    logic [DATA_W-1:0] inst_buf;
    logic [ADDR_W-1:0] data_addr_q;
    logic [DATA_W-1:0] data_wdata_q;
    logic [1:0]        data_size_q;
    logic              data_wr_q;
    logic [DATA_W-1:0] data_buf;

    logic              inst_done;
    logic              data_done;
    logic              post_full;
    logic              post_this;
    logic              data_ok_take;

    assign inst_done = !inst_sram_en || inst_state == DONE;
    assign data_done = !data_sram_en || data_state == DONE;
    assign stall     = !(inst_done && data_done);

    assign inst_sram_rdata = inst_buf;
    assign data_sram_rdata = data_buf;

    // Instruction channel: always a word read.
    assign inst_req   = (inst_state == IDLE && inst_sram_en) || inst_state == ADDR;
    assign inst_wr    = 1'b0;
    assign inst_size  = 2'd2;
    assign inst_wdata = '0;
    assign inst_addr  = (inst_state == IDLE) ? inst_sram_addr : inst_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_state <= IDLE;
            inst_buf   <= '0;
        end else begin
            case (inst_state)
                IDLE: if (inst_sram_en) inst_state <= inst_addr_ok ? DATA : ADDR;
                ADDR: if (inst_addr_ok) inst_state <= DATA;
                DATA: begin
                    if (inst_data_ok) begin
                        inst_buf   <= inst_rdata;
                        inst_state <= DONE;
                    end
                end
                DONE: if (!stall) inst_state <= IDLE;
                default: inst_state <= IDLE;
            endcase
        end
    end

    // Request attributes are captured while idle so they stay put during ADDR.
    always_ff @(posedge clk) begin
        if (inst_state == IDLE) inst_addr_q <= inst_sram_addr;
    end

    always_ff @(posedge clk) begin
        if (data_state == IDLE) begin
            data_addr_q  <= data_sram_addr;
            data_wdata_q <= data_sram_wdata;
            data_size_q  <= size_of(data_sram_wen);
            data_wr_q    <= data_sram_wen != 4'b0000;
        end
    end

    // Data channel bus outputs.
    assign data_req   = (data_state == IDLE && data_sram_en && !post_full) || data_state == ADDR;
    assign data_addr  = (data_state == IDLE) ? data_sram_addr : data_addr_q;
    assign data_wdata = (data_state == IDLE) ? data_sram_wdata : data_wdata_q;
    assign data_size  = (data_state == IDLE) ? size_of(data_sram_wen) : data_size_q;
    assign data_wr    = (data_state == IDLE) ? (data_sram_wen != 4'b0000) : data_wr_q;

`ifdef SRAMLIKE_POSTED_WR_EN
    localparam int CNT_W = $clog2(MAX_POSTED + 1);

    logic [CNT_W-1:0] posted_cnt;
    logic             post_inc;
    logic             post_dec;

    assign post_full    = posted_cnt == CNT_W'(MAX_POSTED);
    assign post_this    = data_wr;
    assign post_inc     = data_req && data_addr_ok && data_wr;
    // Responses are owed to posted writes first; a read only sees data_ok once they drain.
    assign post_dec     = data_data_ok && posted_cnt != '0;
    assign data_ok_take = data_data_ok && posted_cnt == '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            posted_cnt <= '0;
        end else if (post_inc && !post_dec) begin
            posted_cnt <= posted_cnt + CNT_W'(1);
        end else if (post_dec && !post_inc) begin
            posted_cnt <= posted_cnt - CNT_W'(1);
        end
    end
`else
    assign post_full    = 1'b0;
    assign post_this    = 1'b0;
    assign data_ok_take = data_data_ok;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            data_state <= IDLE;
            data_buf   <= '0;
        end else begin
            case (data_state)
                IDLE: begin
                    if (data_sram_en && !post_full) begin
                        if (data_addr_ok) data_state <= post_this ? DONE : DATA;
                        else              data_state <= ADDR;
                    end
                end
                ADDR: if (data_addr_ok) data_state <= post_this ? DONE : DATA;
                DATA: begin
                    if (data_ok_take) begin
                        data_buf   <= data_rdata;
                        data_state <= DONE;
                    end
                end
                DONE: if (!stall) data_state <= IDLE;
                default: data_state <= IDLE;
            endcase
        end
    end

endmodule
